asm_sequencer: RTL and testbench
================================

# asm_sequencer

Sequences one binary fully-connected layer through the ASM accumulate/compare neuron. Per output neuron it fetches pixels, weights and the BN threshold from the layer SRAMs, drives `calculate_en`/`asm_send`/`asm_reception` with the exact cycle alignment the ASM ping-pong accumulator requires, and writes each 1-bit result to the next-layer SRAM. It sits between the top-level layer FSM (`start`/`done`) and one ASM instance plus its memories.

## Interface
- `KW`, 8: width of kernel-length config and of `pix_addr`.
- `NW`, 8: width of output-count config, `bn_addr` and `out_addr`.
- `WAW`, 16: width of `w_addr`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to run a layer; ignored while `busy`.
- `cfg_k`  in  KW  terms per neuron (K), latched on accepted `start`.
- `cfg_n`  in  NW  output neurons (N), latched on accepted `start`.
- `busy`  out  1  layer in progress.
- `done`  out  1  one-cycle pulse at layer end.
- `pix_rd`  out  1  pixel/weight SRAM read strobe (1-cycle read latency).
- `pix_addr`  out  KW  pixel address = term index i.
- `w_addr`  out  WAW  weight address = n*K + i (running counter).
- `bn_rd`  out  1  BN SRAM read strobe.
- `bn_addr`  out  NW  BN address = neuron index n.
- `calculate_en`  out  1  to ASM.
- `asm_reception`  out  1  to ASM; BN data valid this cycle.
- `asm_send`  out  1  to ASM; last term of a neuron is on the data bus this cycle.
- `out_wr`  out  1  next-layer SRAM write strobe; data is ASM `data_out`.
- `out_addr`  out  NW  write address = neuron index.

## Operation
- All outputs registered; reset value 0 for every output and counter; state IDLE.
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: on `start` latch K, N; if K==0 or N==0 go to DONE directly (no reads, no ASM strobes); else go to RUN with i=0, n=0, `w_addr`=0.
- RUN: every cycle `pix_rd`=1, `calculate_en`=1, addresses from (i, n); `bn_rd`=1 when i==0. Increment i; at i==K-1 wrap i to 0 and increment n. `w_addr` increments every read, wraps mod 2^WAW. After issuing (n=N-1, i=K-1) go to DRAIN.
- Delayed strobes (1-cycle pipeline registers, independent of state):
  - `asm_reception` = `bn_rd` delayed 1.
  - `asm_send` = "read issued was i==K-1" delayed 1.
  - `out_wr` = `asm_send` delayed 1; `out_addr` = neuron index of that send.
- DRAIN: `calculate_en`=0, no reads; stays until final `out_wr` has been issued (2 cycles), then DONE.
- DONE: `done`=1 for one cycle, `busy`=0 next, return to IDLE.
- `busy` = 1 in RUN and DRAIN.
- K==1: `asm_reception` and `asm_send` coincide every cycle; legal.
- `start` while busy: ignored; config registers unchanged.
- `rst` low mid-layer: all outputs 0 immediately; no partial `done`.
- Accumulator range: K * max|pixel| must fit the ASM result width; the sequencer does not check this.

## Timing
- `start` sampled at cycle s; first read at s+1; ASM enters CALCULATE at s+2 when the first data arrives.
- Reads occupy s+1 .. s+K*N contiguously with no bubbles between neurons; the ASM accumulates every CALCULATE cycle, so gaps are forbidden.
- Neuron n: `asm_send` at s+1+(n+1)K; `out_wr` at s+2+(n+1)K. `data_out` compares the just-closed bank against BN(n), and BN(n+1) only loads at the end of that cycle.
- Last read r = s+K*N; `calculate_en` low from r+1; final `asm_send` at r+1; final `out_wr` at r+2; `done` at r+3.
- Degenerate case (K or N = 0): `done` at s+2.

## Structure
- Shared package holds the state encoding (one-hot, matching the ASM 5-bit style), the `KW`/`NW`/`WAW` defaults, and the read-latency constant (1).
- Sub-module `strobe_delay`: generic N-bit, D-stage shift register for the reception/send/write pipeline.

## Test plan
- K=3, N=2; pixels 1,2,3; weights n0=1,1,0 and n1=0,0,0; BN n0=-1, n1=0 → `out_wr` at s+5 and s+8 with `data_out` 1 then 0; `done` at s+9.
- K=1, N=4 → `asm_reception` and `asm_send` high s+2..s+5; `out_addr` 0..3 at s+3..s+6.
- `cfg_k`=0 → no `pix_rd`/`calculate_en` ever; `done` at s+2.
- `start` re-pulsed mid-layer with different config → ignored; addresses and `done` timing unchanged.
- Assert `rst` low during RUN → all outputs 0 asynchronously; a fresh `start` afterwards completes normally.
- K=200, N=255, WAW=8 → `w_addr` wraps to 0 after 255; exactly 255 `out_wr` pulses.

Source files
------------

// File: rtl/asm_sequencer_pkg.sv
// Shared definitions for the ASM layer sequencer: default widths, the read latency
// and the one-hot state encoding.
package asm_sequencer_pkg;
    localparam int unsigned KW_DEF  = 8;
    localparam int unsigned NW_DEF  = 8;
    localparam int unsigned WAW_DEF = 16;
    localparam int unsigned RD_LAT  = 1;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        RUN   = 5'b00010,
        DRAIN = 5'b00100,
        DONE  = 5'b01000
    } state_t;
endpackage

// File: rtl/asm_sequencer_if.sv
// Layer-control, memory-strobe and ASM-strobe bundle between the sequencer and its environment.
interface asm_sequencer_if #(
    parameter int unsigned KW  = asm_sequencer_pkg::KW_DEF,
    parameter int unsigned NW  = asm_sequencer_pkg::NW_DEF,
    parameter int unsigned WAW = asm_sequencer_pkg::WAW_DEF
);
    logic           start;
    logic [KW-1:0]  cfg_k;
    logic [NW-1:0]  cfg_n;
    logic           busy;
    logic           done;
    logic           pix_rd;
    logic [KW-1:0]  pix_addr;
    logic [WAW-1:0] w_addr;
    logic           bn_rd;
    logic [NW-1:0]  bn_addr;
    logic           calculate_en;
    logic           asm_reception;
    logic           asm_send;
    logic           out_wr;
    logic [NW-1:0]  out_addr;

    modport master (
        input  start, cfg_k, cfg_n,
        output busy, done, pix_rd, pix_addr, w_addr, bn_rd, bn_addr,
               calculate_en, asm_reception, asm_send, out_wr, out_addr
    );

    modport slave (
        output start, cfg_k, cfg_n,
        input  busy, done, pix_rd, pix_addr, w_addr, bn_rd, bn_addr,
               calculate_en, asm_reception, asm_send, out_wr, out_addr
    );
endinterface

// File: rtl/asm_sequencer_strobe_delay.sv
// Generic W-bit, D-stage shift register with asynchronous active-low clear.
module strobe_delay #(
    parameter int unsigned W = 1,
    parameter int unsigned D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [D];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned j = 0; j < D; j++) stage[j] <= '0;
        end else begin
            stage[0] <= d;
            for (int unsigned j = 1; j < D; j++) stage[j] <= stage[j-1];
        end
    end

    assign q = stage[D-1];
endmodule

// File: rtl/asm_sequencer.sv
// Runs one binary fully-connected layer: K*N back-to-back reads, ASM strobes aligned
// to the returning data, and one next-layer write per neuron.
module asm_sequencer
    import asm_sequencer_pkg::*;
#(
    parameter int unsigned KW  = KW_DEF,
    parameter int unsigned NW  = NW_DEF,
    parameter int unsigned WAW = WAW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    asm_sequencer_if.master bus
);
    state_t        state;
    logic [KW-1:0] k_cfg;
    logic [NW-1:0] n_cfg;
    logic [KW-1:0] k_last;
    logic [NW-1:0] n_last;
    logic          last_term;
    logic [NW-1:0] send_addr;
    logic          send;

    assign k_last    = k_cfg - KW'(1);
    assign n_last    = n_cfg - NW'(1);
    assign last_term = bus.pix_rd && (bus.pix_addr == k_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            k_cfg            <= '0;
            n_cfg            <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.pix_rd       <= 1'b0;
            bus.pix_addr     <= '0;
            bus.w_addr       <= '0;
            bus.bn_rd        <= 1'b0;
            bus.bn_addr      <= '0;
            bus.calculate_en <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        k_cfg        <= bus.cfg_k;
                        n_cfg        <= bus.cfg_n;
                        bus.pix_addr <= '0;
                        bus.bn_addr  <= '0;
                        bus.w_addr   <= '0;
                        if (bus.cfg_k == '0 || bus.cfg_n == '0) begin
                            state <= DONE;
                        end else begin
                            state            <= RUN;
                            bus.busy         <= 1'b1;
                            bus.pix_rd       <= 1'b1;
                            bus.bn_rd        <= 1'b1;
                            bus.calculate_en <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    bus.w_addr <= bus.w_addr + WAW'(1);
                    if (bus.pix_addr == k_last) begin
                        if (bus.bn_addr == n_last) begin
                            state            <= DRAIN;
                            bus.pix_rd       <= 1'b0;
                            bus.bn_rd        <= 1'b0;
                            bus.calculate_en <= 1'b0;
                        end else begin
                            bus.pix_addr <= '0;
                            bus.bn_addr  <= bus.bn_addr + NW'(1);
                            bus.bn_rd    <= 1'b1;
                        end
                    end else begin
                        bus.pix_addr <= bus.pix_addr + KW'(1);
                        bus.bn_rd    <= 1'b0;
                    end
                end
                // One cycle here plus one in DONE covers the final send and write;
                // busy stays up until done is raised.
                DRAIN: state <= DONE;
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    strobe_delay #(.W(2 + NW), .D(RD_LAT)) u_send_dly (
        .clk (clk),
        .rst (rst),
        .d   ({bus.bn_rd, last_term, bus.bn_addr}),
        .q   ({bus.asm_reception, send, send_addr})
    );

    strobe_delay #(.W(1 + NW), .D(1)) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d   ({send, send_addr}),
        .q   ({bus.out_wr, bus.out_addr})
    );

    assign bus.asm_send = send;
endmodule

// File: tb/tb_asm_sequencer.sv
// Self-checking bench: cycle-offset model of the layer schedule plus a tiny ASM/SRAM
// environment for the result bits.
`timescale 1ns/1ps
module tb_asm_sequencer;
    localparam int unsigned KW = 8, NW = 8, WAW = 8;
    localparam int WMOD = 2 ** WAW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    asm_sequencer_if #(.KW(KW), .NW(NW), .WAW(WAW)) bus ();
    asm_sequencer #(.KW(KW), .NW(NW), .WAW(WAW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model of the accepted layer
    bit m_valid = 0;
    int m_s, m_k, m_n, m_idle_from = 0;
    // per-test observations
    int pix_cnt, wr_cnt, recv_cnt, w0_cnt, done_cyc;
    bit done_seen;
    int wr_off_q[$], oa_q[$];
    bit res_q[$];
    // environment memories and ASM stand-in
    int pix_mem [256];
    bit w_mem [256];
    int bn_mem [256];
    bit rd_q = 0, res_reg = 0;
    int term_q = 0, bn_q = 0, bn_reg = 0, acc = 0;
    // expectation scratch
    int d, kn, idx, e_i, e_n, e_w, e_oa;
    bit deg, e_rd, e_bn, e_busy, e_recv, e_send, e_wr, e_done;

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        {e_rd, e_bn, e_busy, e_recv, e_send, e_wr, e_done} = '0;
        e_i = 0; e_n = 0; e_w = 0; e_oa = 0; kn = 0;
        if (rst && m_valid) begin
            d = cyc - m_s;
            kn = m_k * m_n;
            deg = (kn == 0);
            if (!deg) begin
                e_rd = d >= 1 && d <= kn;
                idx = d - 1;
                if (e_rd) begin
                    e_i = idx % m_k; e_n = idx / m_k; e_w = idx % WMOD;
                end
                e_bn   = e_rd && e_i == 0;
                e_busy = d >= 1 && d <= kn + 2;
                e_recv = d >= 2 && d <= kn + 1 && (d - 2) % m_k == 0;
                e_send = d >= m_k + 1 && d <= kn + 1 && (d - 1) % m_k == 0;
                e_wr   = d >= m_k + 2 && d <= kn + 2 && (d - 2) % m_k == 0;
                e_oa   = (d - 2) / m_k - 1;
            end
            e_done = d == (deg ? 2 : kn + 3);
        end
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("pix_rd", bus.pix_rd, e_rd);
        chk("calculate_en", bus.calculate_en, e_rd);
        chk("bn_rd", bus.bn_rd, e_bn);
        chk("asm_reception", bus.asm_reception, e_recv);
        chk("asm_send", bus.asm_send, e_send);
        chk("out_wr", bus.out_wr, e_wr);
        if (e_rd) begin
            chk("pix_addr", bus.pix_addr, e_i);
            chk("w_addr", bus.w_addr, e_w);
        end
        if (e_bn) chk("bn_addr", bus.bn_addr, e_n);
        if (e_wr) chk("out_addr", bus.out_addr, e_oa);

        // observation counters
        if (bus.pix_rd) pix_cnt++;
        if (bus.pix_rd && bus.w_addr == '0) w0_cnt++;
        if (bus.asm_reception) recv_cnt++;
        if (bus.done) begin done_seen = 1; done_cyc = cyc; end
        if (bus.out_wr) begin
            wr_cnt++;
            wr_off_q.push_back(cyc - m_s);
            oa_q.push_back(int'(bus.out_addr));
            res_q.push_back(res_reg);
        end

        // ASM stand-in: data and BN arrive one cycle after their read strobes
        if (rd_q) acc += term_q;
        if (bus.asm_reception) bn_reg = bn_q;
        if (bus.asm_send) begin res_reg = (acc >= bn_reg); acc = 0; end
        rd_q = bus.pix_rd;
        term_q = w_mem[bus.w_addr] ? pix_mem[bus.pix_addr] : -pix_mem[bus.pix_addr];
        if (bus.bn_rd) bn_q = bn_mem[bus.bn_addr];

        if (!rst) begin
            m_valid = 0; m_idle_from = 0;
        end else if (bus.start && cyc >= m_idle_from) begin
            m_valid = 1; m_s = cyc;
            m_k = int'(bus.cfg_k); m_n = int'(bus.cfg_n);
            m_idle_from = (m_k * m_n == 0) ? cyc + 2 : cyc + m_k * m_n + 3;
        end
    end

    task automatic clear_stats();
        pix_cnt = 0; wr_cnt = 0; recv_cnt = 0; w0_cnt = 0; done_cyc = -1; done_seen = 0;
        wr_off_q.delete(); oa_q.delete(); res_q.delete(); acc = 0;
    endtask

    task automatic pulse_start(input int k, input int n, output int s);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_k = KW'(k); bus.cfg_n = NW'(n);
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        while (!done_seen && t < limit) begin @(negedge clk); #1; t++; end
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL done_timeout: no done within %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    initial begin
        int s, s2;
        bus.start = 1'b0; bus.cfg_k = '0; bus.cfg_n = '0;
        foreach (pix_mem[j]) begin pix_mem[j] = 0; w_mem[j] = 0; bn_mem[j] = 0; end
        pix_mem[0] = 1; pix_mem[1] = 2; pix_mem[2] = 3;
        w_mem[0] = 1; w_mem[1] = 1;
        bn_mem[0] = -1; bn_mem[1] = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);

        // K=3, N=2: writes at s+5, s+8 with results 1 then 0, done at s+9
        clear_stats();
        pulse_start(3, 2, s);
        wait_done(40);
        chk("t1_done_off", done_cyc - s, 9);
        chk("t1_nwr", wr_off_q.size(), 2);
        if (wr_off_q.size() == 2) begin
            chk("t1_wr0_off", wr_off_q[0], 5);
            chk("t1_wr1_off", wr_off_q[1], 8);
            chk("t1_res0", res_q[0], 1);
            chk("t1_res1", res_q[1], 0);
        end
        repeat (3) @(posedge clk);

        // K=1, N=4: reception and send coincide, out_addr 0..3
        clear_stats();
        pulse_start(1, 4, s);
        wait_done(40);
        chk("t2_done_off", done_cyc - s, 7);
        chk("t2_recv_cnt", recv_cnt, 4);
        chk("t2_nwr", oa_q.size(), 4);
        if (oa_q.size() == 4) begin
            chk("t2_oa0", oa_q[0], 0);
            chk("t2_oa3", oa_q[3], 3);
            chk("t2_wr0_off", wr_off_q[0], 3);
            chk("t2_wr3_off", wr_off_q[3], 6);
        end
        repeat (3) @(posedge clk);

        // K=0: no reads, done at s+2
        clear_stats();
        pulse_start(0, 5, s);
        wait_done(20);
        chk("t3_done_off", done_cyc - s, 2);
        chk("t3_pix_cnt", pix_cnt, 0);
        repeat (3) @(posedge clk);

        // re-pulse mid-layer with other config: ignored
        clear_stats();
        pulse_start(2, 3, s);
        pulse_start(5, 1, s2);
        wait_done(40);
        chk("t4_done_off", done_cyc - s, 9);
        chk("t4_pix_cnt", pix_cnt, 6);
        chk("t4_nwr", wr_cnt, 3);
        repeat (3) @(posedge clk);

        // asynchronous reset during RUN, then a fresh layer
        clear_stats();
        pulse_start(4, 3, s);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_pix_rd", bus.pix_rd, 0);
        chk("rst_calc", bus.calculate_en, 0);
        chk("rst_w_addr", bus.w_addr, 0);
        chk("rst_pix_addr", bus.pix_addr, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        repeat (20) @(posedge clk);
        chk("rst_no_done", done_seen, 0);
        clear_stats();
        pulse_start(2, 2, s);
        wait_done(40);
        chk("t5_done_off", done_cyc - s, 7);
        repeat (3) @(posedge clk);

        // K=200, N=255: w_addr wraps every 256 reads, 255 writes
        clear_stats();
        pulse_start(200, 255, s);
        wait_done(52000);
        chk("t6_done_off", done_cyc - s, 51003);
        chk("t6_nwr", wr_cnt, 255);
        chk("t6_w0_cnt", w0_cnt, 200);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
